i2c_slave_regmap: RTL and testbench
===================================

Name: i2c_slave_regmap

Overview:
Parametrised I2C slave with an internal register file, addressed through a register pointer.
- Supports multi-byte burst write and read with pointer auto-increment and wrap, repeated START, and NACK on address mismatch or out-of-range pointer.
- Replaces the single-byte slave plus testbench memory with a self-contained, synthesizable peripheral.
- Also exposes a host-side register port so on-chip logic can read and preload registers.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit I2C device address.
MEM_DEPTH, 16, number of 8-bit registers; 2..256.
PTR_W, $clog2(MEM_DEPTH), pointer width; derived, never overridden.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
scl  in  1  I2C clock; slave never stretches
sda  inout  1  I2C data, open-drain: driven 0 when sda_oe=1, else 'z
host_addr  in  PTR_W  host register index
host_we  in  1  host write strobe
host_wdata  in  8  host write data
host_rdata  out  8  mem[host_addr], combinational
host_collision  out  1  1-cycle pulse: host write dropped
wr_valid  out  1  1-cycle pulse: I2C wrote a register
wr_addr  out  PTR_W  register index of that write
wr_data  out  8  byte written
start_detect  out  1  1-cycle pulse on START or repeated START
stop_detect  out  1  1-cycle pulse on STOP
busy  out  1  high from address match until STOP or START

Behaviour:
- **Reset values:** async reset clears all state, the pointer and every mem entry to 0. All outputs are 0 and sda is released.
  - Reset mid-transfer releases sda immediately; the FSM returns to IDLE.
- **Bus sampling:** scl and sda pass through 2-FF synchronizers plus edge detect, giving 3 clk latency.
  - Requirement: the SCL period is at least 16 clk.
- **START / STOP detection:**
  - START = sda falling while scl high.
  - STOP = sda rising while scl high.
  - Both are honoured in every state and override the FSM.
  - START goes to ADDR with the bit counter cleared; the pointer is retained.
  - STOP goes to IDLE with sda released.
- **Bit timing:**
  - Input bits are sampled on the scl rising edge.
  - sda_oe changes only on the scl falling edge.
  - ACK is driven from the falling edge after bit 8 until the falling edge after bit 9.
- **FSM states:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_WAIT, IGNORE.
- **ADDR:** shift in 8 bits, MSB first.
  - [7:1]==SLAVE_ADDR: ACK, set busy, then go to PTR if rw=0, or to RDATA if rw=1 (load mem[ptr] into the shift register).
  - Mismatch: no ACK, go to IGNORE until START or STOP.
- **PTR:** the first byte of a write is the pointer.
  - Value < MEM_DEPTH: ACK, load ptr, go to WDATA.
  - Otherwise: NACK, go to IGNORE; ptr is unchanged.
- **WDATA:** on the 8th rising edge, write mem[ptr] and pulse wr_valid/wr_addr/wr_data in the same cycle. Then ACK and increment ptr, wrapping MEM_DEPTH-1 → 0. Unlimited burst length.
- **RDATA:** shift out MSB first, changing sda on falling edges. A 1 bit means released; a 0 bit means driven.
  - The byte is captured from mem[ptr] at load time, so later writes do not affect the byte in flight.
- **RACK_WAIT:** sample the master's ACK on the 9th rising edge.
  - ACK (0): increment ptr with wrap, load the next byte, go to RDATA.
  - NACK (1): go to IGNORE, sda released.
- **Host port:** host_we writes mem[host_addr] on the clock edge.
  - If an I2C write occurs in the same cycle to the same index, the I2C write wins and host_collision pulses.
  - Different indices both complete.
- The pointer persists across transactions, enabling a write-pointer, repeated START, burst-read sequence.

Decomposition:
- Package i2c_pkg holds:
  - the typedef enum i2c_slv_state_e;
  - localparams I2C_ACK=1'b0 and I2C_NACK=1'b1;
  - a bit-count width constant of 4.
- Sub-module i2c_bus_sync contains the 2-FF synchronizers and the scl_rise/scl_fall/start/stop pulse generation. It is reusable by the master.
- The register file is inline flops in i2c_slave_regmap.

Test Plan:
- Write to 0x50: ptr 0x03, data 0xA1,0xB2 → ACK after every byte; wr_valid pulses twice with (3,A1),(4,B2); host_rdata@3=A1.
- Write pointer 0x02, repeated START, read 3 bytes ACK,ACK,NACK after host preloads regs 2..4 = 11,22,33 → master receives 11,22,33; sda released after NACK; STOP → busy=0.
- Wrap, MEM_DEPTH=16: write ptr 0x0F, data 5A,6B → mem[15]=5A, mem[0]=6B.
- Address 0x51 → NACK (sda high on 9th clock); no wr_valid; busy stays 0; bus ignored until STOP.
- Pointer 0x20 with MEM_DEPTH=16 → NACK on pointer byte; subsequent data ignored; mem unchanged.
- host_we to index 4 in the same cycle as an I2C write to 4 with 0x77 → mem[4]=77, host_collision=1 for one cycle. Assert rst mid-read → sda released within 1 clk and all outputs 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, ACK/NACK bus levels and the bit-counter width.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK_WAIT,
        IGNORE
    } i2c_slv_state_e;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam int   BIT_CNT_W = 4;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into the clk domain and produces registered scl edge and START/STOP pulses.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_bit
);

    // [0] and [1] are the synchronizer pair; [2] holds the previous value for edge detection
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Reset to the idle-bus level so leaving reset never fakes an edge on a quiet bus
            scl_q    <= '1;
            sda_q    <= '1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_q    <= {scl_q[1:0], scl};
            sda_q    <= {sda_q[1:0], sda};
            scl_rise <= scl_q[1] & ~scl_q[2];
            scl_fall <= ~scl_q[1] & scl_q[2];
            start    <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
            stop     <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
        end
    end

    assign sda_bit = sda_q[2];

endmodule

// File: rtl/i2c_slave_regmap.sv
// I2C slave with a pointer-addressed register file, burst read/write with wrap, and a host-side port.
module i2c_slave_regmap
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         MEM_DEPTH  = 16,
    localparam int        PTR_W      = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl,
    inout  wire              sda,
    input  logic [PTR_W-1:0] host_addr,
    input  logic             host_we,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             host_collision,
    output logic             wr_valid,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             start_detect,
    output logic             stop_detect,
    output logic             busy
);

    localparam logic [BIT_CNT_W-1:0] CNT_BYTE = BIT_CNT_W'(8);
    localparam logic [BIT_CNT_W-1:0] CNT_ACK  = BIT_CNT_W'(9);

    i2c_slv_state_e       state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           shreg;
    logic [PTR_W-1:0]     ptr;
    logic                 sda_oe;
    logic [7:0]           mem [MEM_DEPTH];

    logic       scl_rise;
    logic       scl_fall;
    logic       sda_bit;
    logic [7:0] rx_byte;
    logic       ptr_ok;

    i2c_bus_sync u_bus_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start_detect),
        .stop     (stop_detect),
        .sda_bit  (sda_bit)
    );

    assign sda     = sda_oe ? 1'b0 : 1'bz;
    assign rx_byte = {shreg[6:0], sda_bit};
    assign ptr_ok  = ({1'b0, shreg} < 9'(MEM_DEPTH));

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MEM_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (start_detect) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_detect) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise && bit_cnt != CNT_BYTE) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            if (state == WDATA && bit_cnt == BIT_CNT_W'(7)) begin
                                wr_valid <= 1'b1;
                                wr_addr  <= ptr;
                                wr_data  <= rx_byte;
                            end
                        end else if (scl_fall && bit_cnt == CNT_BYTE) begin
                            // Falling edge after bit 8: decide whether to drive ACK for bit 9
                            case (state)
                                ADDR: begin
                                    if (shreg[7:1] == SLAVE_ADDR) begin
                                        sda_oe <= 1'b1;
                                        busy   <= 1'b1;
                                        state  <= ADDR_ACK;
                                    end else begin
                                        state <= IGNORE;
                                    end
                                end
                                PTR: begin
                                    if (ptr_ok) begin
                                        sda_oe <= 1'b1;
                                        ptr    <= shreg[PTR_W-1:0];
                                        state  <= PTR_ACK;
                                    end else begin
                                        state <= IGNORE;
                                    end
                                end
                                default: begin
                                    sda_oe <= 1'b1;
                                    ptr    <= ptr_next(ptr);
                                    state  <= WDATA_ACK;
                                end
                            endcase
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (shreg[0]) begin
                                shreg  <= mem[ptr];
                                sda_oe <= ~mem[ptr][7];
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= PTR;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end else if (scl_fall) begin
                            if (bit_cnt == CNT_BYTE) begin
                                sda_oe <= 1'b0;
                                state  <= RACK_WAIT;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    RACK_WAIT: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            if (sda_bit == I2C_ACK) ptr <= ptr_next(ptr);
                            else                    state <= IGNORE;
                        end else if (scl_fall && bit_cnt == CNT_ACK) begin
                            shreg   <= mem[ptr];
                            sda_oe  <= ~mem[ptr][7];
                            bit_cnt <= '0;
                            state   <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file is architecturally visible and must read 0 after reset, so every entry is reset here
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
            host_collision <= 1'b0;
        end else begin
            host_collision <= host_we && wr_valid && (host_addr == wr_addr);
            // NOTE: with two non-blocking writes to the same entry the later statement wins, which gives I2C priority
            if (host_we)  mem[host_addr] <= host_wdata;
            if (wr_valid) mem[wr_addr]   <= wr_data;
        end
    end

    assign host_rdata = mem[host_addr];

endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Directed bench: bit-banged I2C master plus host-port stimulus against i2c_slave_regmap (SLAVE_ADDR 0x50, 16 regs).
module tb_i2c_slave_regmap;
    import i2c_pkg::*;

    localparam int QTR = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    logic [3:0] host_addr = '0;
    logic       host_we = 1'b0;
    logic [7:0] host_wdata = '0;

    wire        sda;
    wire  [7:0] host_rdata;
    wire        host_collision;
    wire        wr_valid;
    wire  [3:0] wr_addr;
    wire  [7:0] wr_data;
    wire        start_detect;
    wire        stop_detect;
    wire        busy;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_regmap #(.SLAVE_ADDR(7'h50), .MEM_DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .scl            (scl),
        .sda            (sda),
        .host_addr      (host_addr),
        .host_we        (host_we),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .host_collision (host_collision),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .start_detect   (start_detect),
        .stop_detect    (stop_detect),
        .busy           (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] wr_q[$];
    int start_cnt = 0;
    int stop_cnt  = 0;
    int coll_cnt  = 0;

    always @(negedge clk) begin
        if (wr_valid)       wr_q.push_back({wr_addr, wr_data});
        if (start_detect)   start_cnt++;
        if (stop_detect)    stop_cnt++;
        if (host_collision) coll_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic qwait();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_low = 1'b0; qwait();
        scl = 1'b1;     qwait();
        sda_low = 1'b1; qwait();
        scl = 1'b0;     qwait();
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; qwait();
        scl = 1'b1;     qwait();
        sda_low = 1'b0; qwait();
        repeat (8) @(negedge clk);
    endtask

    task automatic put_bit(input logic b);
        sda_low = ~b; qwait();
        scl = 1'b1;   qwait(); qwait();
        scl = 1'b0;   qwait();
    endtask

    task automatic get_bit(output logic b);
        sda_low = 1'b0; qwait();
        scl = 1'b1;     qwait();
        b = sda;        qwait();
        scl = 1'b0;     qwait();
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(input logic ack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) get_bit(v[i]);
        put_bit(ack);
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        #1;
        check(tag, host_rdata, exp);
    endtask

    // Waits for the next I2C register write and issues a host write in that very cycle
    task automatic host_wr_on_i2c(input logic [3:0] a, input logic [7:0] d);
        logic seen = 1'b0;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(negedge clk);
            seen = wr_valid;
        end
        check("coll_wait", seen, 1'b1);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    logic       ack;
    logic [7:0] rd;
    logic       b;
    int         wbase;
    int         sbase;
    int         cbase;

    initial begin
        repeat (4) @(negedge clk);
        check("rst_sda", sda, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        peek("rst_mem7", 4'd7, 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Burst write A1,B2 starting at register 3
        wbase = wr_q.size();
        bus_start();
        put_byte(8'hA0, ack); check("t1_addr_ack", ack, I2C_ACK);
        check("t1_busy", busy, 1'b1);
        put_byte(8'h03, ack); check("t1_ptr_ack", ack, I2C_ACK);
        put_byte(8'hA1, ack); check("t1_d0_ack", ack, I2C_ACK);
        put_byte(8'hB2, ack); check("t1_d1_ack", ack, I2C_ACK);
        bus_stop();
        check("t1_busy_end", busy, 1'b0);
        check("t1_wr_cnt", wr_q.size() - wbase, 2);
        check("t1_wr0", wr_q[wbase], {4'h3, 8'hA1});
        check("t1_wr1", wr_q[wbase+1], {4'h4, 8'hB2});
        peek("t1_mem3", 4'd3, 8'hA1);

        // Pointer write, repeated START, 3-byte burst read
        host_wr(4'd2, 8'h11);
        host_wr(4'd3, 8'h22);
        host_wr(4'd4, 8'h33);
        sbase = start_cnt;
        bus_start();
        put_byte(8'hA0, ack); check("t2_addr_ack", ack, I2C_ACK);
        put_byte(8'h02, ack); check("t2_ptr_ack", ack, I2C_ACK);
        bus_start();
        put_byte(8'hA1, ack); check("t2_raddr_ack", ack, I2C_ACK);
        get_byte(I2C_ACK, rd);  check("t2_rd0", rd, 8'h11);
        get_byte(I2C_ACK, rd);  check("t2_rd1", rd, 8'h22);
        get_byte(I2C_NACK, rd); check("t2_rd2", rd, 8'h33);
        #1;
        check("t2_sda_rel", sda, 1'b1);
        check("t2_busy_pre_stop", busy, 1'b1);
        check("t2_starts", start_cnt - sbase, 2);
        sbase = stop_cnt;
        bus_stop();
        check("t2_busy_end", busy, 1'b0);
        check("t2_stops", stop_cnt - sbase, 1);

        // Pointer wrap 15 -> 0
        wbase = wr_q.size();
        bus_start();
        put_byte(8'hA0, ack);
        put_byte(8'h0F, ack); check("t3_ptr_ack", ack, I2C_ACK);
        put_byte(8'h5A, ack);
        put_byte(8'h6B, ack); check("t3_d1_ack", ack, I2C_ACK);
        bus_stop();
        check("t3_wr0", wr_q[wbase], {4'hF, 8'h5A});
        check("t3_wr1", wr_q[wbase+1], {4'h0, 8'h6B});
        peek("t3_mem15", 4'd15, 8'h5A);
        peek("t3_mem0", 4'd0, 8'h6B);

        // Wrong device address is ignored until STOP
        wbase = wr_q.size();
        bus_start();
        put_byte(8'hA2, ack); check("t4_addr_nack", ack, I2C_NACK);
        check("t4_busy", busy, 1'b0);
        put_byte(8'h05, ack); check("t4_ign_ack", ack, I2C_NACK);
        put_byte(8'h99, ack);
        bus_stop();
        check("t4_no_wr", wr_q.size() - wbase, 0);
        peek("t4_mem5", 4'd5, 8'h00);

        // Out-of-range pointer: NACK, data ignored, pointer kept at 1
        host_wr(4'd1, 8'h3C);
        wbase = wr_q.size();
        bus_start();
        put_byte(8'hA0, ack);
        put_byte(8'h20, ack); check("t5_ptr_nack", ack, I2C_NACK);
        put_byte(8'hEE, ack); check("t5_data_nack", ack, I2C_NACK);
        bus_stop();
        check("t5_no_wr", wr_q.size() - wbase, 0);
        peek("t5_mem0", 4'd0, 8'h6B);
        bus_start();
        put_byte(8'hA1, ack);
        get_byte(I2C_NACK, rd); check("t5_ptr_kept", rd, 8'h3C);
        bus_stop();

        // Same-index host/I2C collision, then different-index concurrent writes
        cbase = coll_cnt;
        fork
            begin
                bus_start();
                put_byte(8'hA0, ack);
                put_byte(8'h04, ack);
                put_byte(8'h77, ack);
                bus_stop();
            end
            host_wr_on_i2c(4'd4, 8'hCC);
        join
        peek("t6_mem4", 4'd4, 8'h77);
        check("t6_coll", coll_cnt - cbase, 1);
        fork
            begin
                bus_start();
                put_byte(8'hA0, ack);
                put_byte(8'h05, ack);
                put_byte(8'h55, ack);
                bus_stop();
            end
            host_wr_on_i2c(4'd9, 8'h99);
        join
        peek("t6_mem5", 4'd5, 8'h55);
        peek("t6_mem9", 4'd9, 8'h99);
        check("t6_no_coll", coll_cnt - cbase, 1);

        // Reset in the middle of a read of register 6 (all-zero byte keeps sda driven)
        bus_start();
        put_byte(8'hA1, ack); check("t7_addr_ack", ack, I2C_ACK);
        get_bit(b);
        get_bit(b);
        check("t7_sda_driven", sda, 1'b0);
        rst = 1'b1;
        #1;
        check("t7_sda_rel", sda, 1'b1);
        @(negedge clk);
        check("t7_busy", busy, 1'b0);
        check("t7_wr_valid", wr_valid, 1'b0);
        check("t7_coll", host_collision, 1'b0);
        check("t7_start", start_detect, 1'b0);
        check("t7_stop", stop_detect, 1'b0);
        peek("t7_mem4", 4'd4, 8'h00);
        rst = 1'b0;
        bus_stop();
        check("t7_busy_after", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
